// File: rtl/mod_updown_counter.sv
// Up/down counter over 0..limit with run-time step, wrap or saturate mode,
// synchronous parallel load and registered one-cycle wrap/saturation pulses.
module mod_updown_counter #(
  parameter int                WIDTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_n,
  input  logic             ce,
  input  logic             up_down,
  input  logic             sat_en,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] data_load,
  output logic [WIDTH-1:0] count_out,
  output logic             max_count,
  output logic             zero,
  output logic             wrap_pls,
  output logic             sat_pls
);

  // All range arithmetic is one bit wider so limit+1 and count+step never overflow.
  logic [WIDTH:0] lim_x;
  logic [WIDTH:0] mod_x;
  logic [WIDTH:0] step_x;
  logic [WIDTH:0] s_x;
  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] up_sum;
  logic [WIDTH:0] up_wrap;
  logic [WIDTH:0] dn_wrap;

  logic [WIDTH-1:0] count_d;
  logic             wrap_d;
  logic             sat_d;

  assign lim_x   = {1'b0, limit};
  assign mod_x   = lim_x + {{WIDTH{1'b0}}, 1'b1};
  assign step_x  = {1'b0, step};
  assign s_x     = (step_x > mod_x) ? mod_x : step_x;
  assign cnt_x   = {1'b0, count_out};
  assign up_sum  = cnt_x + s_x;
  assign up_wrap = up_sum - mod_x;
  assign dn_wrap = cnt_x + mod_x - s_x;

  always_comb begin
    count_d = count_out;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;
    if (!load_n) begin
      count_d = (data_load > limit) ? limit : data_load;
    end else if (count_out > limit) begin
      // Limit was lowered under the current count: pull back into range.
      count_d = sat_en ? limit : '0;
    end else if (ce && (step != '0)) begin
      if (up_down) begin
        if (up_sum <= lim_x) begin
          count_d = WIDTH'(up_sum);
        end else if (sat_en) begin
          count_d = limit;
          sat_d   = 1'b1;
        end else begin
          count_d = WIDTH'(up_wrap);
          wrap_d  = 1'b1;
        end
      end else begin
        if (cnt_x >= s_x) begin
          count_d = WIDTH'(cnt_x - s_x);
        end else if (sat_en) begin
          count_d = '0;
          sat_d   = 1'b1;
        end else begin
          count_d = WIDTH'(dn_wrap);
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_out <= RESET_VAL;
      wrap_pls  <= 1'b0;
      sat_pls   <= 1'b0;
    end else begin
      count_out <= count_d;
      wrap_pls  <= wrap_d;
      sat_pls   <= sat_d;
    end
  end

  assign max_count = (count_out == limit);
  assign zero      = (count_out == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: integer-arithmetic reference model checked
// every negedge, plus directed scenarios with literal expected values.
module tb_mod_updown_counter;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_n;
  logic             ce;
  logic             up_down;
  logic             sat_en;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] data_load;
  logic [WIDTH-1:0] count_out;
  logic             max_count;
  logic             zero;
  logic             wrap_pls;
  logic             sat_pls;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  mod_updown_counter #(.WIDTH(WIDTH), .RESET_VAL('0)) dut (
    .clk(clk), .rst(rst), .load_n(load_n), .ce(ce), .up_down(up_down),
    .sat_en(sat_en), .step(step), .limit(limit), .data_load(data_load),
    .count_out(count_out), .max_count(max_count), .zero(zero),
    .wrap_pls(wrap_pls), .sat_pls(sat_pls)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: act=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the range 0..limit.
  function automatic logic [WIDTH+1:0] model_next(
    input int c, input int lim, input int st, input int dl,
    input logic ld_n, input logic en, input logic up, input logic sat);
    int m, s, nc;
    logic w, p;
    m  = lim + 1;
    s  = (st < m) ? st : m;
    nc = c;
    w  = 1'b0;
    p  = 1'b0;
    if (!ld_n) nc = (dl < lim) ? dl : lim;
    else if (c > lim) nc = sat ? lim : 0;
    else if (en && st != 0) begin
      if (up) begin
        if (c + s <= lim) nc = c + s;
        else if (sat) begin nc = lim; p = 1'b1; end
        else begin nc = (c + s) % m; w = 1'b1; end
      end else begin
        if (c - s >= 0) nc = c - s;
        else if (sat) begin nc = 0; p = 1'b1; end
        else begin nc = (((c - s) % m) + m) % m; w = 1'b1; end
      end
    end
    return {w, p, nc[WIDTH-1:0]};
  endfunction

  logic [WIDTH-1:0] m_count;
  logic             m_wrap;
  logic             m_sat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_count <= '0;
      m_wrap  <= 1'b0;
      m_sat   <= 1'b0;
    end else begin
      {m_wrap, m_sat, m_count} <= model_next(int'(m_count), int'(limit), int'(step),
                                             int'(data_load), load_n, ce, up_down, sat_en);
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_count", int'(count_out), int'(m_count));
      check("model_wrap",  int'(wrap_pls),  int'(m_wrap));
      check("model_sat",   int'(sat_pls),   int'(m_sat));
      check("model_max",   int'(max_count), int'(m_count == limit));
      check("model_zero",  int'(zero),      int'(m_count == '0));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input int v);
    load_n    = 1'b0;
    data_load = WIDTH'(v);
    tick();
    load_n    = 1'b1;
  endtask

  initial begin
    rst = 1'b0; load_n = 1'b1; ce = 1'b0; up_down = 1'b1; sat_en = 1'b0;
    step = 4'd1; limit = 4'd9; data_load = '0;
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", int'(count_out), 0);
    check("reset_zero",  int'(zero), 1);
    check("reset_wrap",  int'(wrap_pls), 0);
    check("reset_sat",   int'(sat_pls), 0);
    @(negedge clk);
    rst = 1'b0;

    // decade wrap 0..9 then 0
    ce = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("decade_count", int'(count_out), i % 10);
      check("decade_wrap",  int'(wrap_pls), (i == 10) ? 1 : 0);
      if (i == 9) check("decade_max", int'(max_count), 1);
    end

    // load clamps to limit and beats ce
    load_n = 1'b0; data_load = 4'd12;
    tick();
    load_n = 1'b1;
    check("load_clamp", int'(count_out), 9);
    check("load_max",   int'(max_count), 1);
    check("load_wrap",  int'(wrap_pls), 0);

    // step-3 wrap down from 1
    load_val(1);
    up_down = 1'b0; step = 4'd3;
    tick();
    check("down_wrap_count", int'(count_out), 8);
    check("down_wrap_pls",   int'(wrap_pls), 1);
    tick();
    check("down_next_count", int'(count_out), 5);
    check("down_next_pls",   int'(wrap_pls), 0);

    // saturation up from 7 and down from 2
    ce = 1'b0;
    load_val(7);
    ce = 1'b1; up_down = 1'b1; step = 4'd4; sat_en = 1'b1;
    tick();
    check("sat_up_count", int'(count_out), 9);
    check("sat_up_pls",   int'(sat_pls), 1);
    tick();
    check("sat_hold_count", int'(count_out), 9);
    check("sat_hold_pls",   int'(sat_pls), 1);
    load_val(2);
    up_down = 1'b0;
    tick();
    check("sat_dn_count", int'(count_out), 0);
    check("sat_dn_pls",   int'(sat_pls), 1);

    // limit lowered under the count, ce=0: wrap mode then sat mode
    ce = 1'b0; sat_en = 1'b0;
    load_val(8);
    limit = 4'd5;
    tick();
    check("fix_wrap_count", int'(count_out), 0);
    check("fix_wrap_pls",   int'(wrap_pls), 0);
    limit = 4'd9;
    load_val(8);
    limit = 4'd5; sat_en = 1'b1;
    tick();
    check("fix_sat_count", int'(count_out), 5);
    check("fix_sat_pls",   int'(sat_pls), 0);

    // limit=15 step=15 from 15 wraps to 14
    limit = 4'd15; sat_en = 1'b0;
    load_val(15);
    ce = 1'b1; up_down = 1'b1; step = 4'd15;
    tick();
    check("edge15_count", int'(count_out), 14);
    check("edge15_wrap",  int'(wrap_pls), 1);

    // step=0 holds
    step = 4'd0;
    tick();
    check("step0_count", int'(count_out), 14);
    check("step0_wrap",  int'(wrap_pls), 0);

    // limit=0 pins count, pulses every enabled cycle
    limit = 4'd0; step = 4'd1;
    tick();
    check("lim0_fix_count", int'(count_out), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lim0_count", int'(count_out), 0);
      check("lim0_wrap",  int'(wrap_pls), 1);
    end
    sat_en = 1'b1;
    tick();
    check("lim0_sat", int'(sat_pls), 1);
    check("lim0_sat_nowrap", int'(wrap_pls), 0);

    // async reset mid-operation clears count and a live pulse
    limit = 4'd9; sat_en = 1'b0; ce = 1'b0;
    load_val(8);
    ce = 1'b1; step = 4'd3;
    tick();
    check("pre_rst_count", int'(count_out), 1);
    check("pre_rst_wrap",  int'(wrap_pls), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_count", int'(count_out), 0);
    check("async_rst_wrap",  int'(wrap_pls), 0);
    @(negedge clk);
    rst = 1'b0;

    // mixed vectors, checked by the model only
    for (int i = 0; i < 120; i++) begin
      load_n    = ($urandom_range(0, 9) != 0);
      ce        = ($urandom_range(0, 3) != 0);
      up_down   = 1'($urandom_range(0, 1));
      sat_en    = 1'($urandom_range(0, 1));
      step      = WIDTH'($urandom_range(0, 15));
      data_load = WIDTH'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) limit = WIDTH'($urandom_range(0, 15));
      tick();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
